// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C slave datapath.
// Holds the transmit-engine state encoding and bus-level constants.
package i2c_slave_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      ACK_WAIT,
      ACK_HOLD,
      DONE
   } data_out_state_t;

   localparam logic       I2C_ACK   = 1'b0;
   localparam logic       I2C_NACK  = 1'b1;
   localparam logic [7:0] IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/data_out_controller_if.sv
// Bus bundle between the I2C read-data engine and its surroundings.
// The slave modport is the engine's view; master is the driving environment.
interface data_out_controller_if #(
   parameter int NUM_BYTES = 6
);
   localparam int CNT_W = $clog2(NUM_BYTES + 1);

   logic                      SCL;
   logic                      SCL_prev;
   logic                      SDA;
   logic                      SDA_prev;
   logic                      enable;
   logic [NUM_BYTES-1:0][7:0] tx_data;
   logic                      sda_oe;
   logic [CNT_W-1:0]          byte_count;
   logic                      nack_received;
   logic                      done;

   modport slave (
      input  SCL, SCL_prev, SDA, SDA_prev, enable, tx_data,
      output sda_oe, byte_count, nack_received, done
   );

   modport master (
      output SCL, SCL_prev, SDA, SDA_prev, enable, tx_data,
      input  sda_oe, byte_count, nack_received, done
   );

endinterface

// File: rtl/data_out_shift_reg.sv
// 8-bit load/shift-left register feeding the SDA output path.
// Exposes the current MSB and the bit that becomes MSB after the next shift.
module data_out_shift_reg
   import i2c_slave_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_i,
   input  logic [7:0] load_val_i,
   input  logic       shift_i,
   output logic       msb_o,
   output logic       next_msb_o
);

   logic [7:0] shift_q;
   logic [7:0] shift_d;

   // NOTE: default assignment first so every path assigns shift_d; no latch.
   always_comb begin
      shift_d = shift_q;
      if (load_i) begin
         shift_d = load_val_i;
      end else if (shift_i) begin
         shift_d = {shift_q[6:0], 1'b1};
      end
   end

   // NOTE: non-blocking in clocked logic so all registers update together.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shift_q <= IDLE_BYTE;
      end else begin
         shift_q <= shift_d;
      end
   end

   assign msb_o      = shift_q[7];
   assign next_msb_o = shift_q[6];

endmodule

// File: rtl/data_out_controller.sv
// I2C slave transmit engine for master reads: shifts preloaded bytes onto SDA MSB first.
// Define DATA_OUT_WRAP_EN to wrap the byte index to 0 after the last byte instead of sending 0xFF.
module data_out_controller
   import i2c_slave_pkg::*;
#(
   parameter int NUM_BYTES = 6
) (
   input  logic                  FPGA_clk,
   input  logic                  rst,
   data_out_controller_if.slave  bus
);

   localparam int                CNT_W    = $clog2(NUM_BYTES + 1);
   localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(NUM_BYTES - 1);
   localparam logic [CNT_W-1:0] IDX_END  = CNT_W'(NUM_BYTES);
`ifdef DATA_OUT_WRAP_EN
   localparam logic [CNT_W-1:0] IDX_AFTER_LAST = '0;
`else
   localparam logic [CNT_W-1:0] IDX_AFTER_LAST = IDX_END;
`endif

   data_out_state_t           state_q, state_d;
   logic [2:0]                bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0]          byte_idx_q, byte_idx_d;
   logic [CNT_W-1:0]          byte_count_q, byte_count_d;
   logic                      sda_oe_q, sda_oe_d;
   logic                      nack_q, nack_d;
   logic                      done_q, done_d;
   logic [NUM_BYTES-1:0][7:0] tx_mem_q;

   logic                      fall, rise, stop;
   logic                      tx_capture;
   logic                      shift_load, shift_en;
   logic [7:0]                load_val;
   logic                      msb, next_msb;
   logic [CNT_W-1:0]          nxt_idx;

   assign fall = bus.SCL_prev & ~bus.SCL;
   assign rise = ~bus.SCL_prev & bus.SCL;
   assign stop = bus.SCL & bus.SCL_prev & bus.SDA & ~bus.SDA_prev;

   data_out_shift_reg u_shift (
      .clk        (FPGA_clk),
      .rst_n      (rst),
      .load_i     (shift_load),
      .load_val_i (load_val),
      .shift_i    (shift_en),
      .msb_o      (msb),
      .next_msb_o (next_msb)
   );

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      byte_idx_d   = byte_idx_q;
      byte_count_d = byte_count_q;
      sda_oe_d     = sda_oe_q;
      nack_d       = nack_q;
      done_d       = done_q;
      tx_capture   = 1'b0;
      shift_load   = 1'b0;
      shift_en     = 1'b0;
      load_val     = IDLE_BYTE;
      nxt_idx      = (byte_idx_q >= IDX_LAST) ? IDX_AFTER_LAST : byte_idx_q + CNT_W'(1);

      if (state_q != IDLE && stop) begin
         sda_oe_d = 1'b0;
         done_d   = 1'b1;
         state_d  = DONE;
      end else if (state_q != IDLE && !bus.enable) begin
         sda_oe_d = 1'b0;
         state_d  = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.enable) begin
                  tx_capture   = 1'b1;
                  shift_load   = 1'b1;
                  load_val     = bus.tx_data[0];
                  sda_oe_d     = ~bus.tx_data[0][7];
                  bit_cnt_d    = 3'd7;
                  byte_idx_d   = '0;
                  byte_count_d = '0;
                  nack_d       = 1'b0;
                  done_d       = 1'b0;
                  state_d      = SHIFT;
               end
            end
            SHIFT: begin
               if (fall && bit_cnt_q != 3'd0) begin
                  shift_en  = 1'b1;
                  sda_oe_d  = ~next_msb;
                  bit_cnt_d = bit_cnt_q - 3'd1;
               end else if (fall) begin
                  sda_oe_d = 1'b0;
                  state_d  = ACK_WAIT;
               end
            end
            ACK_WAIT: begin
               if (rise && bus.SDA == I2C_ACK) begin
                  if (byte_count_q != IDX_END) byte_count_d = byte_count_q + CNT_W'(1);
                  byte_idx_d = nxt_idx;
                  shift_load = 1'b1;
                  load_val   = (nxt_idx < IDX_END) ? tx_mem_q[nxt_idx] : IDLE_BYTE;
                  state_d    = ACK_HOLD;
               end else if (rise) begin
                  nack_d  = 1'b1;
                  done_d  = 1'b1;
                  state_d = DONE;
               end
            end
            ACK_HOLD: begin
               // sda_oe stays released through the ACK high phase; drive only after the fall.
               if (fall) begin
                  sda_oe_d  = ~msb;
                  bit_cnt_d = 3'd7;
                  state_d   = SHIFT;
               end
            end
            DONE: begin
               sda_oe_d = 1'b0;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge FPGA_clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         bit_cnt_q    <= 3'd0;
         byte_idx_q   <= '0;
         byte_count_q <= '0;
         sda_oe_q     <= 1'b0;
         nack_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         byte_idx_q   <= byte_idx_d;
         byte_count_q <= byte_count_d;
         sda_oe_q     <= sda_oe_d;
         nack_q       <= nack_d;
         done_q       <= done_d;
      end
   end

   // NOTE: the byte store is not reset; it is always written on leaving IDLE before use.
   always_ff @(posedge FPGA_clk) begin
      if (tx_capture) tx_mem_q <= bus.tx_data;
   end

   assign bus.sda_oe        = sda_oe_q;
   assign bus.byte_count    = byte_count_q;
   assign bus.nack_received = nack_q;
   assign bus.done          = done_q;

endmodule
